// File: rtl/store_dispatch_unit_pkg.sv
// Shared types and helpers for the store dispatch unit: mem_u_b_h_w encodings,
// store-buffer entry layout and the push-time lane formatting.
package store_dispatch_unit_pkg;

    localparam int SB_ADDR_W  = 32;
    localparam int SB_WDATA_W = 32;
    localparam int SB_BE_W    = 4;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef struct packed {
        logic [SB_ADDR_W-1:0]  addr;
        logic [SB_WDATA_W-1:0] wdata;
        logic [SB_BE_W-1:0]    be;
    } sb_entry_t;

    // Bit 2 (unsigned) has no meaning for stores; encoding 11 is treated as misaligned.
    function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] lo);
        logic bad;
        case (ctrl[1:0])
            MEM_BYTE: bad = 1'b0;
            MEM_HALF: bad = lo[0];
            MEM_WORD: bad = |lo;
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic sb_entry_t format_store(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [2:0] ctrl);
        sb_entry_t e;
        e.addr = {addr[31:2], 2'b00};
        case (ctrl[1:0])
            MEM_BYTE: begin
                e.be    = 4'b0001 << addr[1:0];
                e.wdata = {4{data[7:0]}};
            end
            MEM_HALF: begin
                e.be    = 4'b0011 << addr[1:0];
                e.wdata = {2{data[15:0]}};
            end
            default: begin
                e.be    = 4'b1111;
                e.wdata = data;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/store_dispatch_unit_rr_arbiter.sv
// Round-robin arbiter over the store RS entries: picks the first requester at or
// after rr_ptr (wrapping) and advances rr_ptr past the winner when a grant is taken.
module store_rr_arbiter #(
    parameter int NUM_RS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RS-1:0]         req,
    input  logic                      grant_en,
    output logic [NUM_RS-1:0]         grant,
    output logic [$clog2(NUM_RS)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_RS);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             found;

    always_comb begin
        int idx;
        idx       = 0;
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_RS;
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        grant    = '0;
        rr_ptr_d = rr_ptr_q;
        if (grant_en && found) begin
            grant[grant_idx] = 1'b1;
            rr_ptr_d = (grant_idx == IDX_W'(NUM_RS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/store_dispatch_unit.sv
// Store dispatch: grants one ready store RS entry per cycle into an in-order store
// buffer, drains the head over a req/ack write port and flags load/store word hazards.
module store_dispatch_unit
    import store_dispatch_unit_pkg::*;
#(
    parameter int NUM_RS = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_RS-1:0]        rs_data_ready,
    input  logic [NUM_RS*32-1:0]     rs_addr,
    input  logic [NUM_RS*32-1:0]     rs_data,
    input  logic [NUM_RS*3-1:0]      rs_mem_ctrl,
    output logic [NUM_RS-1:0]        rs_result_taken,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     mem_ack,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hazard,
    output logic                     misalign_err,
    output logic [$clog2(DEPTH):0]   sb_count
);

    localparam int IDX_W = $clog2(NUM_RS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_RS-1:0][31:0] rs_addr_v;
    logic [NUM_RS-1:0][31:0] rs_data_v;
    logic [NUM_RS-1:0][2:0]  rs_ctrl_v;

    assign rs_addr_v = rs_addr;
    assign rs_data_v = rs_data;
    assign rs_ctrl_v = rs_mem_ctrl;

    sb_entry_t        sb_q [DEPTH];
    sb_entry_t        sb_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             grant_en;
    logic [IDX_W-1:0] win_idx;
    logic             granted;
    logic             win_misaligned;
    sb_entry_t        win_entry;
    sb_entry_t        head;
    logic             push;
    logic             pop;
    logic             not_empty;
    logic             unused_ld_lo;

    // A full buffer never accepts, even when the head pops this same cycle.
    assign grant_en = !rst && !flush && (count_q < CNT_W'(DEPTH)) && |rs_data_ready;

    store_rr_arbiter #(.NUM_RS(NUM_RS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (rs_data_ready),
        .grant_en  (grant_en),
        .grant     (rs_result_taken),
        .grant_idx (win_idx)
    );

    assign granted        = |rs_result_taken;
    assign win_misaligned = is_misaligned(rs_ctrl_v[win_idx], rs_addr_v[win_idx][1:0]);
    assign win_entry      = format_store(rs_addr_v[win_idx], rs_data_v[win_idx], rs_ctrl_v[win_idx]);
    assign misalign_err   = granted && win_misaligned;

    assign not_empty = (count_q != '0);
    assign push      = granted && !win_misaligned;
    // Head is only valid once an entry is resident, so ack on an empty buffer never pops.
    assign pop       = not_empty && mem_ack;

    always_comb begin
        sb_d     = sb_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            sb_d[wr_ptr_q] = win_entry;
            wr_ptr_d       = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        sb_q <= sb_d;
    end

    assign head      = sb_q[rd_ptr_q];
    assign mem_req   = not_empty;
    assign mem_addr  = not_empty ? head.addr  : '0;
    assign mem_wdata = not_empty ? head.wdata : '0;
    assign mem_be    = not_empty ? head.be    : '0;
    assign sb_count  = count_q;

    // Only resident entries are compared; a store granted this cycle is not yet visible.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        ld_hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (sb_q[idx].addr[31:2] == ld_addr[31:2]))
                ld_hazard = 1'b1;
        end
    end

    assign unused_ld_lo = ^ld_addr[1:0];

endmodule
